// File: rtl/fsm_transition_monitor.sv
// Passive FSM observer: turns each change of `state` into a {from, to, dwell} record queued in a small FIFO.
// Optional feature macro: FSM_MON_DWELL_EN builds the dwell counter; otherwise rec_dwell is tied to zero.
module fsm_transition_monitor #(
    parameter int unsigned STATE_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DWELL_WIDTH = 8,
    parameter int unsigned DROP_WIDTH  = 8
) (
    input  logic                         clock_port,
    input  logic                         reset_port,
    input  logic [STATE_WIDTH-1:0]       reset_value,
    input  logic [STATE_WIDTH-1:0]       state,
    output logic                         transition,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [STATE_WIDTH-1:0]       rec_from,
    output logic [STATE_WIDTH-1:0]       rec_to,
    output logic [DWELL_WIDTH-1:0]       rec_dwell,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic [DROP_WIDTH-1:0]        drop_count,
    input  logic                         clear
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]      PTR_ONE  = 1;
    localparam logic [DROP_WIDTH-1:0] DROP_ONE = 1;

    logic [STATE_WIDTH-1:0] prev_state;
    logic [PTR_W:0]         wr_ptr;
    logic [PTR_W:0]         rd_ptr;
    logic [PTR_W-1:0]       wr_idx;
    logic [PTR_W-1:0]       rd_idx;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;

    logic [STATE_WIDTH-1:0] mem_from [FIFO_DEPTH];
    logic [STATE_WIDTH-1:0] mem_to   [FIFO_DEPTH];

    assign transition = !reset_port && (state != prev_state);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign wr_idx     = wr_ptr[PTR_W-1:0];
    assign rd_idx     = rd_ptr[PTR_W-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
    assign fifo_level = wr_ptr - rd_ptr;

    assign rec_valid  = !fifo_empty;
    assign pop        = rec_valid && rec_ready;
    assign push_ok    = transition && (!fifo_full || pop);
    assign drop       = transition && fifo_full && !pop;

    assign rec_from   = mem_from[rd_idx];
    assign rec_to     = mem_to[rd_idx];

    always_ff @(posedge clock_port) begin
        if (reset_port) begin
            prev_state <= reset_value;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            prev_state <= state;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A clear on the same edge as a drop discards that drop as well.
            if (clear) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_ONE;
                end
            end
        end
    end

`ifdef FSM_MON_DWELL_EN
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = 1;

    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [DWELL_WIDTH-1:0] mem_dwell [FIFO_DEPTH];

    always_ff @(posedge clock_port) begin
        if (reset_port) begin
            dwell_cnt <= '0;
        end else if (transition) begin
            dwell_cnt <= '0;
        end else if (dwell_cnt != '1) begin
            dwell_cnt <= dwell_cnt + DWELL_ONE;
        end
    end

    always_ff @(posedge clock_port) begin
        if (push_ok) begin
            mem_dwell[wr_idx] <= dwell_cnt;
        end
    end

    assign rec_dwell = mem_dwell[rd_idx];
`else
    assign rec_dwell = '0;
`endif

    // Record storage is not reset; rec_valid guards every read.
    always_ff @(posedge clock_port) begin
        if (push_ok) begin
            mem_from[wr_idx] <= prev_state;
            mem_to[wr_idx]   <= state;
        end
    end

endmodule

// File: doc/fsm_transition_monitor.md
# fsm_transition_monitor

Passive observer for any generated FSM: it reads the `state` output of an FSM instance, detects each state change, and turns it into a {from, to, dwell} transition record. Records are queued in a small FIFO and drained through a valid/ready port. It is the reading end of the FSM state interface and sits beside an FSM instance in debug and verification builds. It never drives the FSM.

## Interface
Parameters:
- `STATE_WIDTH`, 4: width of observed state and record fields.
- `FIFO_DEPTH`, 4: record FIFO entries; power of two, ≥2.
- `DWELL_WIDTH`, 8: dwell counter width; saturating.
- `DROP_WIDTH`, 8: drop counter width; saturating.

Ports. One clock; reset is synchronous and active-high.
- `clock_port`, in, 1: clock.
- `reset_port`, in, 1: synchronous active-high reset.
- `reset_value`, in, STATE_WIDTH: the observed FSM's reset state; loaded into `prev_state` on reset.
- `state`, in, STATE_WIDTH: observed FSM current state.
- `transition`, out, 1: combinational, `state != prev_state` and not in reset.
- `rec_valid`, out, 1: FIFO head valid.
- `rec_ready`, in, 1: consumer accepts the head.
- `rec_from`, out, STATE_WIDTH: head record, source state.
- `rec_to`, out, STATE_WIDTH: head record, destination state.
- `rec_dwell`, out, DWELL_WIDTH: head record, cycles spent in the source state.
- `fifo_level`, out, clog2(FIFO_DEPTH)+1: occupied entries.
- `overflow`, out, 1: sticky; set when a record is dropped.
- `drop_count`, out, DROP_WIDTH: dropped records, saturating.
- `clear`, in, 1: clears `overflow` and `drop_count`. Does not affect the FIFO.

## Operation
- `prev_state <= state` on every non-reset edge. Transition is detected when `state != prev_state`.
- `dwell_cnt` on each edge: 0 if a transition occurs, otherwise saturating +1.
- Push: on a transition edge, the record {prev_state, state, dwell_cnt} is written to the FIFO tail.
- Pop: on an edge with `rec_valid && rec_ready`.
- Full with a push and no pop: the record is dropped. Set `overflow` and increment `drop_count` (saturating at all-ones).
- Full with push and pop on the same edge: both are accepted; level stays at FIFO_DEPTH and nothing is dropped.
- Empty with a push: no bypass. The record becomes visible on the next cycle.
- `clear` on the same edge as a drop: the clear wins. `overflow` = 0 and `drop_count` = 0.
- `rec_*` fields are don't-care while `rec_valid` = 0; the bench must not check them.

Reset. The following hold on the edge with `reset_port` = 1, and reset is honoured mid-stream:
- `prev_state` = `reset_value`; `dwell_cnt` = 0.
- FIFO flushed: `rec_valid` = 0 and `fifo_level` = 0.
- `overflow` = 0 and `drop_count` = 0.
- `transition` = 0 while reset is asserted.
- No record is produced for the reset edge itself, even if `state` differs.

## Timing
- Transition seen in cycle t: the record is written at the end of t. `rec_valid` = 1 in t+1 if the FIFO was empty.
- Back-to-back transitions every cycle produce one record per cycle, each with dwell 0.
- `fifo_level` and `overflow` are registered and update one cycle after the causing edge.
- `rec_valid` depends only on FIFO state and has no combinational path from `rec_ready`.
- Throughput: one push and one pop per cycle.

## Configuration
- `FSM_MON_DWELL_EN` defined: the dwell counter is built and `rec_dwell` carries the measured dwell.
- `FSM_MON_DWELL_EN` undefined: no dwell counter or FIFO dwell storage. `rec_dwell` ties to 0. All other behaviour is unchanged.

## Test plan
- Reset path: `reset_value` = 0xb, `state` held at 0xb for 3 cycles after reset, then 0xc. Expect one record {0xb, 0xc, 3} with `rec_valid` one cycle later.
- Back-to-back: `state` sequence b,c,b,c on consecutive cycles with `rec_ready` = 1. Expect records {b,c,0}, {c,b,0}, {b,c,0}, one per cycle.
- Overflow: `rec_ready` = 0 and 6 transitions with FIFO_DEPTH = 4. Expect `fifo_level` = 4, `overflow` = 1, `drop_count` = 2. Assert `clear`: expect `overflow` = 0 and `drop_count` = 0, with the FIFO still holding 4.
- Full with simultaneous push and pop: FIFO full, `rec_ready` = 1 and a transition on the same cycle. Expect `fifo_level` stays 4, `drop_count` unchanged and record order preserved.
- Saturation: `state` constant for 300 cycles, then changes, with DWELL_WIDTH = 8. Expect `rec_dwell` = 255.
- Reset mid-stream: assert `reset_port` with 2 records queued and `state` ≠ `reset_value`. Expect `rec_valid` = 0, `fifo_level` = 0, and no record for the reset edge.
